// File: rtl/wts_channel_mixer.sv
// Wave-table channel mixer: walks each channel once per sample period and
// accumulates volume-scaled wave RAM samples into one signed mixed sample.
module wts_channel_mixer #(
    parameter int CHANNELS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mix_start,
    output logic [2:0]  ch_sel,
    input  logic [6:0]  ch_wave_address,
    input  logic [3:0]  ch_volume,
    input  logic        ch_enable,
    output logic        ram_rd,
    output logic [9:0]  ram_address,
    input  logic [7:0]  ram_rdata,
    output logic [10:0] mix_out,
    output logic        mix_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        MAC
    } state_t;

    localparam logic [2:0] LAST_CH = 3'(CHANNELS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_ch_sel;
    logic signed [14:0] r_acc;
    logic [10:0]        r_mix_out;
    logic               r_mix_valid;

    logic signed [11:0] w_prod;
    logic signed [11:0] w_term;
    logic signed [14:0] w_sum;
    logic               w_last;

    // Volume is unsigned, so it is widened with a zero before the signed multiply.
    assign w_prod = $signed(ram_rdata) * $signed({1'b0, ch_volume});
    assign w_term = ch_enable ? w_prod : 12'sd0;
    assign w_sum  = r_acc + {{3{w_term[11]}}, w_term};
    assign w_last = (r_ch_sel >= LAST_CH);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (mix_start) w_next = READ;
            READ:    w_next = MAC;
            MAC:     w_next = w_last ? IDLE : READ;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ch_sel    <= 3'd0;
            r_acc       <= 15'sd0;
            r_mix_out   <= 11'd0;
            r_mix_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_mix_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mix_start) begin
                        r_acc    <= 15'sd0;
                        r_ch_sel <= 3'd0;
                    end
                end
                MAC: begin
                    if (!w_last) begin
                        r_acc    <= w_sum;
                        r_ch_sel <= r_ch_sel + 3'd1;
                    end else begin
                        // Arithmetic shift by 4: keep bits [14:4] of the sum.
                        r_mix_out   <= w_sum[14:4];
                        r_mix_valid <= 1'b1;
                        r_ch_sel    <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ch_sel      = r_ch_sel;
    assign ram_rd      = (r_state == READ);
    assign ram_address = {r_ch_sel, ch_wave_address};
    assign busy        = (r_state != IDLE);
    assign mix_out     = r_mix_out;
    assign mix_valid   = r_mix_valid;

endmodule

// File: tb/tb_wts_channel_mixer.sv
// Directed-vector bench for wts_channel_mixer with per-channel input muxes
// and a one-cycle-latency wave RAM model.
module tb_wts_channel_mixer;

    logic        clk;
    logic        reset;
    logic        mix_start;
    logic [2:0]  ch_sel;
    logic [6:0]  ch_wave_address;
    logic [3:0]  ch_volume;
    logic        ch_enable;
    logic        ram_rd;
    logic [9:0]  ram_address;
    logic [7:0]  ram_rdata;
    logic [10:0] mix_out;
    logic        mix_valid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] cur_samp [8];
    logic [3:0] cur_vol  [8];
    logic       cur_en   [8];
    logic [6:0] cur_wa   [8];

    wts_channel_mixer #(.CHANNELS(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .mix_start       (mix_start),
        .ch_sel          (ch_sel),
        .ch_wave_address (ch_wave_address),
        .ch_volume       (ch_volume),
        .ch_enable       (ch_enable),
        .ram_rd          (ram_rd),
        .ram_address     (ram_address),
        .ram_rdata       (ram_rdata),
        .mix_out         (mix_out),
        .mix_valid       (mix_valid),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ch_wave_address = cur_wa[ch_sel];
    assign ch_volume       = cur_vol[ch_sel];
    assign ch_enable       = cur_en[ch_sel];

    // Junk data when not read so a mistimed sample shows up in the sum.
    always @(posedge clk)
        ram_rdata <= ram_rd ? cur_samp[ram_address[9:7]] : 8'hA5;

    typedef struct {
        logic [39:0] samp;
        logic [19:0] vol;
        logic [4:0]  en;
        logic [10:0] exp_mix;
        string       name;
    } vec_t;

    vec_t tv [7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 5; i++) begin
            cur_samp[i] = v.samp[i*8 +: 8];
            cur_vol[i]  = v.vol[i*4 +: 4];
            cur_en[i]   = v.en[i];
        end
    endtask

    // Pulses mix_start and watches cycles k+1..k+11 against the fixed schedule.
    task automatic run_pass(input int repulse, output logic [10:0] res,
                            output int rd_err, output int bsy_err,
                            output int vld_err, output int adr_err);
        int ch;
        rd_err = 0; bsy_err = 0; vld_err = 0; adr_err = 0; res = '0;
        @(negedge clk);
        mix_start = 1'b1;
        @(posedge clk);
        #1;
        mix_start = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            if (n > 1) begin
                @(posedge clk);
                #1;
            end
            mix_start = (n == repulse);
            ch = (n - 1) / 2;
            if (ram_rd !== ((n % 2 == 1) && (n <= 9))) rd_err++;
            if (busy !== (n <= 10)) bsy_err++;
            if (mix_valid !== (n == 11)) vld_err++;
            if (n <= 10 && ch_sel !== 3'(ch)) adr_err++;
            if (n <= 9 && (n % 2 == 1) &&
                ram_address !== {3'(ch), cur_wa[ch]}) adr_err++;
            if (n == 11) res = mix_out;
        end
        mix_start = 1'b0;
    endtask

    logic [10:0] res;
    int e_rd, e_bsy, e_vld, e_adr, vcnt;

    initial begin
        tv[0] = '{40'h40_40_40_40_40, 20'hFFFFF, 5'b11111, 11'd300,   "all_0x40"};
        tv[1] = '{40'h80_80_80_80_80, 20'hFFFFF, 5'b11111, 11'h5A8,   "all_neg128"};
        tv[2] = '{40'h7F_7F_7F_7F_7F, 20'hFF1FF, 5'b00100, 11'd7,     "only_ch2"};
        tv[3] = '{40'h7F_7F_7F_7F_FF, 20'hFFFF1, 5'b00001, 11'h7FF,   "floor_neg1"};
        tv[4] = '{40'h40_40_40_40_40, 20'hFFFFF, 5'b00000, 11'd0,     "all_off"};
        tv[5] = '{40'h01_80_7F_F0_10, 20'h0FF53, 5'b11111, 11'h7FD,   "mixed"};
        tv[6] = '{40'h7F_7F_7F_7F_7F, 20'hFFFFF, 5'b11111, 11'd595,   "max_pos"};

        for (int i = 0; i < 8; i++) begin
            cur_samp[i] = 8'h00;
            cur_vol[i]  = 4'h0;
            cur_en[i]   = 1'b0;
            cur_wa[i]   = 7'h00;
        end
        cur_wa[0] = 7'h00; cur_wa[1] = 7'h1F; cur_wa[2] = 7'h20;
        cur_wa[3] = 7'h7F; cur_wa[4] = 7'h55;

        mix_start = 1'b0;
        reset     = 1'b0;
        #2 reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ch_sel", ch_sel, 0);
        check("rst_ram_rd", ram_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_mix_valid", mix_valid, 0);
        check("rst_mix_out", mix_out, 0);
        @(negedge clk);
        reset = 1'b0;

        // Consecutive passes: each new start lands in the mix_valid cycle.
        for (int v = 0; v < 7; v++) begin
            load(tv[v]);
            run_pass(0, res, e_rd, e_bsy, e_vld, e_adr);
            check({tv[v].name, "_mix"}, res, tv[v].exp_mix);
            check({tv[v].name, "_ram_rd"}, e_rd, 0);
            check({tv[v].name, "_busy"}, e_bsy, 0);
            check({tv[v].name, "_valid"}, e_vld, 0);
            check({tv[v].name, "_addr"}, e_adr, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("hold_mix_out", mix_out, 595);
        check("idle_busy", busy, 0);

        load(tv[0]);
        run_pass(4, res, e_rd, e_bsy, e_vld, e_adr);
        check("repulse_mix", res, 300);
        check("repulse_valid", e_vld, 0);
        check("repulse_busy", e_bsy, 0);
        vcnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (mix_valid || busy) vcnt++;
        end
        check("repulse_no_requeue", vcnt, 0);

        load(tv[1]);
        @(negedge clk);
        mix_start = 1'b1;
        @(posedge clk);
        #1;
        mix_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_ch_sel", ch_sel, 0);
        check("midrst_ram_rd", ram_rd, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", mix_valid, 0);
        check("midrst_mix_out", mix_out, 0);
        @(negedge clk);
        reset = 1'b0;
        vcnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (mix_valid || busy) vcnt++;
        end
        check("midrst_abandoned", vcnt, 0);

        load(tv[1]);
        run_pass(0, res, e_rd, e_bsy, e_vld, e_adr);
        check("after_rst_mix", res, 11'h5A8);
        check("after_rst_valid", e_vld, 0);
        check("after_rst_addr", e_adr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
